mem_unit_param: RTL

Parametrised successor to the single-cycle word memory: a synchronous, word-addressable data memory with configurable data width, depth and access latency. Adds per-byte write strobes, an explicit `ready`/`ack` handshake with a three-state controller, and an error response for misaligned or out-of-range accesses. Sits on the processor's load/store path behind the memory stage and serves one outstanding request at a time.

---
 rtl/mem_unit_param.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/mem_unit_param.sv
// rtl/mem_unit_param.sv - parametrised word memory with byte strobes, wait states and error response
// Optional feature macro MEM_CLEAR_ON_RESET_EN: zero-sweep of the array after reset.
module mem_unit_param #(
  parameter int DATA_W      = 32,
  parameter int ADDR_W      = 32,
  parameter int DEPTH       = 1024,
  parameter int WAIT_CYCLES = 0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                req,
  input  logic                we,
  input  logic [DATA_W/8-1:0] be,
  input  logic [ADDR_W-1:0]   addr,
  input  logic [DATA_W-1:0]   wdata,
  output logic                ready,
  output logic                ack,
  output logic                err,
  output logic [DATA_W-1:0]   rdata
);
  localparam int NB    = DATA_W / 8;
  localparam int OFF_W = $clog2(NB);
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {
    IDLE,
    WAIT_ST,
    RESP
`ifdef MEM_CLEAR_ON_RESET_EN
    , CLEAR
`endif
  } state_t;

  state_t             state;
  logic [3:0]         wait_cnt;
  logic               cap_we;
  logic               cap_err;
  logic [IDX_W-1:0]   cap_idx;
  logic [DATA_W-1:0]  mem [DEPTH];
`ifdef MEM_CLEAR_ON_RESET_EN
  logic [IDX_W-1:0]   clr_idx;
`endif

  logic [ADDR_W-1:0]  req_idx;
  logic               req_err;
  logic               accept;

  assign req_idx = addr >> OFF_W;
  assign req_err = (|(addr & ADDR_W'(NB - 1))) || (req_idx >= ADDR_W'(DEPTH));
  assign accept  = (state == IDLE) && req && !rst;

  // Response source: live request when answering straight from IDLE, captured copy after WAIT.
  logic [IDX_W-1:0]   rd_idx;
  logic               rd_err;
  logic               rd_we;

  assign rd_idx = (state == IDLE) ? req_idx[IDX_W-1:0] : cap_idx;
  assign rd_err = (state == IDLE) ? req_err : cap_err;
  assign rd_we  = (state == IDLE) ? we : cap_we;

  logic               mem_wr;
  logic [IDX_W-1:0]   mem_widx;
  logic [NB-1:0]      mem_wbe;
  logic [DATA_W-1:0]  mem_wdata;

  always_comb begin
    mem_wr    = accept && we && !req_err;
    mem_widx  = req_idx[IDX_W-1:0];
    mem_wbe   = be;
    mem_wdata = wdata;
`ifdef MEM_CLEAR_ON_RESET_EN
    if (state == CLEAR && !rst) begin
      mem_wr    = 1'b1;
      mem_widx  = clr_idx;
      mem_wbe   = '1;
      mem_wdata = '0;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (mem_wr) begin
      for (int i = 0; i < NB; i++) begin
        if (mem_wbe[i]) mem[mem_widx][8*i +: 8] <= mem_wdata[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
`ifdef MEM_CLEAR_ON_RESET_EN
      state   <= CLEAR;
      ready   <= 1'b0;
      clr_idx <= '0;
`else
      state   <= IDLE;
      ready   <= 1'b1;
`endif
      ack      <= 1'b0;
      err      <= 1'b0;
      rdata    <= '0;
      wait_cnt <= '0;
      cap_we   <= 1'b0;
      cap_err  <= 1'b0;
      cap_idx  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req) begin
            cap_we  <= we;
            cap_err <= req_err;
            cap_idx <= req_idx[IDX_W-1:0];
            ready   <= 1'b0;
            if (WAIT_CYCLES > 0) begin
              state    <= WAIT_ST;
              wait_cnt <= '0;
            end else begin
              state <= RESP;
              ack   <= 1'b1;
              err   <= rd_err;
              if (!rd_we) rdata <= rd_err ? '0 : mem[rd_idx];
            end
          end
        end
        WAIT_ST: begin
          if (wait_cnt == 4'(WAIT_CYCLES - 1)) begin
            state    <= RESP;
            wait_cnt <= '0;
            ack      <= 1'b1;
            err      <= rd_err;
            if (!rd_we) rdata <= rd_err ? '0 : mem[rd_idx];
          end else begin
            wait_cnt <= wait_cnt + 4'd1;
          end
        end
        RESP: begin
          state <= IDLE;
          ack   <= 1'b0;
          err   <= 1'b0;
          ready <= 1'b1;
        end
`ifdef MEM_CLEAR_ON_RESET_EN
        CLEAR: begin
          if (clr_idx == IDX_W'(DEPTH - 1)) begin
            state   <= IDLE;
            ready   <= 1'b1;
            clr_idx <= '0;
          end else begin
            clr_idx <= clr_idx + IDX_W'(1);
          end
        end
`endif
        default: state <= IDLE;
      endcase
    end
  end

endmodule
